// File: rtl/serial_feeder_pkg.sv
// Shared types and constants for the serial word feeder.
package serial_feeder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRERST = 2'd1,
        SHIFT  = 2'd2
    } feeder_state_e;

    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Mod-WIDTH bit index counter with load-to-zero, increment and terminal count.
module bit_index_counter
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] idx,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (inc)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign idx = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/serial_word_feeder.sv
// Serializes WIDTH-bit words LSB-first onto a bit detector input.
// Define SERIAL_WORD_FEEDER_PRERST_EN to pulse fsm_rst for one cycle before each word.
module serial_word_feeder
    import serial_feeder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             b,
    output logic             bit_valid,
    output logic [CNT_W-1:0] bit_idx,
    output logic             fsm_rst,
    output logic             word_done
);

`ifdef SERIAL_WORD_FEEDER_PRERST_EN
    localparam feeder_state_e START_STATE = PRERST;
`else
    localparam feeder_state_e START_STATE = SHIFT;
`endif

    feeder_state_e    state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             xfer;
    logic             tc;
    logic             in_shift;

    assign in_shift = (state_q == SHIFT);
    // in_ready depends only on registered state, so the handshake has no loop.
    assign in_ready = (state_q == IDLE) || (in_shift && tc);
    assign xfer     = in_valid && in_ready;

    bit_index_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .load (xfer),
        .inc  (in_shift && !tc),
        .idx  (bit_idx),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE:    if (xfer) state_d = START_STATE;
            PRERST:  state_d = SHIFT;
            SHIFT:   if (tc) state_d = xfer ? START_STATE : IDLE;
            default: state_d = IDLE;
        endcase
        if (xfer)
            shift_d = in_word;
        else if (in_shift)
            shift_d = shift_q >> 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    assign b         = in_shift && shift_q[0];
    assign bit_valid = in_shift;
    assign word_done = in_shift && tc;

`ifdef SERIAL_WORD_FEEDER_PRERST_EN
    assign fsm_rst = (state_q == PRERST);
`else
    assign fsm_rst = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder; follows SERIAL_WORD_FEEDER_PRERST_EN like the RTL.
module tb_serial_word_feeder;

    localparam int W = 32;
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in_word = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, b, bit_valid, fsm_rst, word_done;
    logic [4:0]    bit_idx;
    logic [9:0]    obs;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    serial_word_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b         (b),
        .bit_valid (bit_valid),
        .bit_idx   (bit_idx),
        .fsm_rst   (fsm_rst),
        .word_done (word_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {bit_valid, b, fsm_rst, word_done, in_ready, bit_idx}
    assign obs = {bit_valid, b, fsm_rst, word_done, in_ready, bit_idx};

    function automatic logic [9:0] shift_exp(input logic [W-1:0] w, input int i);
        return {1'b1, w[i], 1'b0, i == W-1, i == W-1, 5'(i)};
    endfunction

    localparam logic [9:0] PRE_EXP   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    localparam logic [9:0] RST_EXP   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    localparam logic [9:0] AFTER_EXP = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31};

    task automatic test_reset();
        in_valid = 1'b1;
        in_word  = 32'hFFFF_FFFF;
        rst      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (obs !== RST_EXP) begin
                miscompares++;
                $display("FAIL reset_hold: got %b expected %b", obs, RST_EXP);
            end
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (obs !== RST_EXP) begin
                miscompares++;
                $display("FAIL reset_release: got %b expected %b", obs, RST_EXP);
            end
        end
    endtask

    task automatic test_single(input logic [W-1:0] w);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 1", in_ready);
        end
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = '0;
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
        vectors++;
        if (obs !== PRE_EXP) begin
            miscompares++;
            $display("FAIL single_prerst: got %b expected %b", obs, PRE_EXP);
        end
        @(negedge clk);
`endif
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (obs !== shift_exp(w, i)) begin
                miscompares++;
                $display("FAIL single_bit%0d: got %b expected %b", i, obs, shift_exp(w, i));
            end
            @(negedge clk);
        end
        vectors++;
        if (obs !== AFTER_EXP) begin
            miscompares++;
            $display("FAIL single_idle: got %b expected %b", obs, AFTER_EXP);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        int done1, done2;
        w1 = 32'h55BF_5D41;
        w2 = 32'h54C5_2B45;
        done1 = -1;
        done2 = -1;
        @(negedge clk);
        in_word  = w1;
        in_valid = 1'b1;
        @(negedge clk);
        in_word  = w2;
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
        vectors++;
        if (obs !== PRE_EXP) begin
            miscompares++;
            $display("FAIL b2b_prerst1: got %b expected %b", obs, PRE_EXP);
        end
        @(negedge clk);
`endif
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (obs !== shift_exp(w1, i)) begin
                miscompares++;
                $display("FAIL b2b_w1_bit%0d: got %b expected %b", i, obs, shift_exp(w1, i));
            end
            if (word_done) done1 = cyc;
            @(negedge clk);
        end
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
        vectors++;
        if (obs !== PRE_EXP) begin
            miscompares++;
            $display("FAIL b2b_prerst2: got %b expected %b", obs, PRE_EXP);
        end
        in_valid = 1'b0;
        @(negedge clk);
`endif
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (obs !== shift_exp(w2, i)) begin
                miscompares++;
                $display("FAIL b2b_w2_bit%0d: got %b expected %b", i, obs, shift_exp(w2, i));
            end
            if (word_done) done2 = cyc;
            @(negedge clk);
        end
        vectors++;
        if (done2 - done1 !== W + PRE) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d expected %0d", done2 - done1, W + PRE);
        end
        vectors++;
        if (obs !== AFTER_EXP) begin
            miscompares++;
            $display("FAIL b2b_idle: got %b expected %b", obs, AFTER_EXP);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w1, w2;
        w1 = 32'h0F0F_1234;
        w2 = 32'hA5C3_9617;
        @(negedge clk);
        in_word  = w1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 32'h0;
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
        vectors++;
        if (obs !== PRE_EXP) begin
            miscompares++;
            $display("FAIL bp_prerst1: got %b expected %b", obs, PRE_EXP);
        end
        @(negedge clk);
`endif
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (obs !== shift_exp(w1, i)) begin
                miscompares++;
                $display("FAIL bp_w1_bit%0d: got %b expected %b", i, obs, shift_exp(w1, i));
            end
            if (i == 5)  begin in_valid = 1'b1; in_word = 32'hDEAD_BEEF; end
            if (i == 20) in_word = 32'hCAFE_F00D;
            if (i == W-1) in_word = w2;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_word  = 32'hFFFF_FFFF;
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
        vectors++;
        if (obs !== PRE_EXP) begin
            miscompares++;
            $display("FAIL bp_prerst2: got %b expected %b", obs, PRE_EXP);
        end
        @(negedge clk);
`endif
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (obs !== shift_exp(w2, i)) begin
                miscompares++;
                $display("FAIL bp_w2_bit%0d: got %b expected %b", i, obs, shift_exp(w2, i));
            end
            @(negedge clk);
        end
        vectors++;
        if (obs !== AFTER_EXP) begin
            miscompares++;
            $display("FAIL bp_idle: got %b expected %b", obs, AFTER_EXP);
        end
    endtask

    task automatic test_midword_reset();
        logic [W-1:0] w;
        w = 32'h1357_9BDF;
        @(negedge clk);
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef SERIAL_WORD_FEEDER_PRERST_EN
        @(negedge clk);
`endif
        for (int i = 0; i <= 10; i++) begin
            vectors++;
            if (obs !== shift_exp(w, i)) begin
                miscompares++;
                $display("FAIL mid_bit%0d: got %b expected %b", i, obs, shift_exp(w, i));
            end
            if (i < 10) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== RST_EXP) begin
            miscompares++;
            $display("FAIL mid_async_reset: got %b expected %b", obs, RST_EXP);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== RST_EXP) begin
                miscompares++;
                $display("FAIL mid_no_done%0d: got %b expected %b", i, obs, RST_EXP);
            end
        end
        test_single(32'h2468_ACE0);
    endtask

    initial begin
        test_reset();
        test_single(32'h93AA_574E);
        test_back_to_back();
        test_backpressure();
        test_midword_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
